mem_line_arbiter: RTL and testbench
===================================

Name: mem_line_arbiter

Overview:
Sits directly downstream of the I-cache refill path, the D-cache refill/writeback path and the page-table walker, and upstream of the unified line memory. It arbitrates their line-granular requests round-robin and serialises them onto the single memory port, one transaction at a time. It returns a one-cycle done pulse plus the read line to the granted requester. It owns no storage beyond the captured request and the response line.

Parameters:
XLEN, 32, word width in bits
ADDR_BITS, 20, word-address width on all address ports
WORDS_PER_LINE, 4, words per memory line; line width LINE_BITS = XLEN*WORDS_PER_LINE

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
ic_req  in  1  I-cache line read request (level, held until ic_done)
ic_addr  in  ADDR_BITS  I-cache word address
ic_done  out  1  one-cycle completion pulse to I-cache
dc_req  in  1  D-cache request (level, held until dc_done)
dc_we  in  1  1 = writeback line, 0 = refill read
dc_addr  in  ADDR_BITS  D-cache word address
dc_wdata  in  LINE_BITS  writeback line
dc_done  out  1  one-cycle completion pulse to D-cache
ptw_req  in  1  page-table walker line read request (level)
ptw_addr  in  ADDR_BITS  PTW word address
ptw_done  out  1  one-cycle completion pulse to PTW
rdata  out  LINE_BITS  response line, shared by all requesters, valid with any done
mem_req  out  1  one-cycle memory command strobe
mem_we  out  1  memory write enable, valid with mem_req
mem_addr  out  ADDR_BITS  line-aligned word address
mem_wdata  out  LINE_BITS  write line
mem_done  in  1  memory completion pulse (read data valid)
mem_rdata  in  LINE_BITS  memory read line
busy  out  1  high in every state except IDLE
gnt_id  out  2  current/last grant: 0 = PTW, 1 = D-cache, 2 = I-cache

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- Reset: state = IDLE. The following outputs are 0: all done signals, mem_req, mem_we, mem_addr, mem_wdata, rdata, busy, gnt_id. The round-robin pointer is set so that the priority order is PTW > D > I. Reset mid-transaction aborts the transaction with no done pulse. The memory shares rst.
- IDLE: if any req is high, select a winner, capture its addr, we and wdata, then go to ISSUE. If no req is high, stay in IDLE.
- Arbitration: round-robin over {PTW, D, I}. The search starts at the requester after the last granted one.
- Simultaneous requests: only the winner is served. The others wait, and are guaranteed service within 2 further transactions.
- ISSUE: mem_req = 1 for exactly this cycle. mem_addr = captured addr with its low log2(WORDS_PER_LINE) bits cleared. mem_we = captured we; this is 0 for PTW and I. Go to WAIT.
- WAIT: hold until mem_done. On mem_done:
  - reads load rdata from mem_rdata;
  - writes leave rdata unchanged;
  - go to RESP.
- mem_done outside WAIT is ignored.
- RESP: assert the winner's done for exactly one cycle, then go to IDLE.
- Requesters drop req at the edge on which they see done. The arbiter re-samples req only in IDLE, so a dropped req is never re-granted.
- Minimum transaction latency is 4 cycles from grant to done (IDLE→ISSUE→WAIT→RESP), with mem_done in the first WAIT cycle.
- rdata holds its value until the next read completes.
- Requester payload may change after grant without effect, because it is captured in IDLE.

Decomposition:
- Shared package: LINE_BITS derivation, OFFSET_BITS = log2(WORDS_PER_LINE), requester ID constants (REQ_PTW = 0, REQ_DC = 1, REQ_IC = 2), FSM state encoding.
- One natural sub-module: rr_arbiter3. It is combinational winner selection from req[2:0] and last_gnt, producing a one-hot grant plus a valid flag; the pointer register lives in the parent.

Test Plan:
- Single I read: ic_req with ic_addr = 0x13; memory returns 0xDEADBEEF_..._00000001 after 3 WAIT cycles -> mem_addr = 0x10, mem_we = 0, ic_done pulses at grant+6, rdata equals the memory line, gnt_id = 2.
- Simultaneous ptw_req, dc_req, ic_req immediately after reset -> service order PTW, D, I. Each done pulses exactly once, with no overlap.
- Continuous contention between dc_req and ic_req over 6 transactions -> grants alternate D, I, D, I, D, I.
- D writeback: dc_we = 1, dc_addr = 0x24, dc_wdata = {4{0x0000_00AA}} -> mem_we = 1, mem_addr = 0x24, mem_wdata as given, rdata unchanged, dc_done pulses.
- Reset asserted in WAIT -> next cycle busy = 0, no done pulse. A stale mem_done is ignored. The post-reset request is granted PTW-first.
- Spurious mem_done in IDLE and in ISSUE -> no state change, no done pulse.

Source files
------------

// File: rtl/mem_line_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_line_arbiter_pkg
// Shared definitions for the line-memory arbiter slice.
//   - default sizing (word width, word-address width, words per line)
//   - derived line width and line-offset width
//   - requester ID constants (also used as grant-vector bit positions)
//   - FSM state encoding
//   - small helpers for round-robin stepping and size derivation
// -----------------------------------------------------------------------------
package mem_line_arbiter_pkg;

  // Default sizing; the top module exposes these as overridable parameters.
  localparam int XLEN_DEF           = 32;
  localparam int ADDR_BITS_DEF      = 20;
  localparam int WORDS_PER_LINE_DEF = 4;
  localparam int LINE_BITS_DEF      = XLEN_DEF * WORDS_PER_LINE_DEF;
  localparam int OFFSET_BITS_DEF    = $clog2(WORDS_PER_LINE_DEF);

  localparam int NUM_REQ = 3;

  // Requester IDs double as bit positions in the request/grant vectors.
  localparam logic [1:0] REQ_PTW = 2'd0;
  localparam logic [1:0] REQ_DC  = 2'd1;
  localparam logic [1:0] REQ_IC  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Line width in bits for a given word width and line length.
  function automatic int line_bits(input int xlen, input int words_per_line);
    return xlen * words_per_line;
  endfunction

  // Next requester in the circular order PTW -> DC -> IC -> PTW.
  // The unused encoding 3 maps to PTW so a corrupted pointer still
  // yields a full, legal search order.
  function automatic logic [1:0] rr_next(input logic [1:0] id);
    logic [1:0] nxt;
    case (id)
      REQ_PTW: nxt = REQ_DC;
      REQ_DC:  nxt = REQ_IC;
      default: nxt = REQ_PTW;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mem_line_arbiter_rr_arbiter3.sv
// -----------------------------------------------------------------------------
// rr_arbiter3
// Combinational three-way round-robin winner selection. The search starts
// at the requester after last_gnt_i and wraps around, so the most recently
// served requester has the lowest priority. The pointer register itself
// lives in the parent; this block only looks at it.
//
// Ports
//   req_i       [2:0]  request vector, bit index = requester ID
//   last_gnt_i  [1:0]  ID of the most recently granted requester
//   gnt_o       [2:0]  one-hot grant (all zero when no request)
//   valid_o            at least one request is present
// -----------------------------------------------------------------------------
module rr_arbiter3
  import mem_line_arbiter_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [1:0] last_gnt_i,
  output logic [2:0] gnt_o,
  output logic       valid_o
);

  logic [1:0] firstId;
  logic [1:0] secondId;
  logic [1:0] thirdId;

  // Search order derived from the pointer: the two requesters after the
  // last winner come first, the last winner itself comes last.
  assign firstId  = rr_next(last_gnt_i);
  assign secondId = rr_next(firstId);
  assign thirdId  = rr_next(secondId);

  assign valid_o = |req_i;

  // Pick the first active request along the rotated search order.
  always_comb begin
    gnt_o = 3'b000;
    if (req_i[firstId]) begin
      gnt_o[firstId] = 1'b1;
    end else if (req_i[secondId]) begin
      gnt_o[secondId] = 1'b1;
    end else if (req_i[thirdId]) begin
      gnt_o[thirdId] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_line_arbiter.sv
// -----------------------------------------------------------------------------
// mem_line_arbiter
// Arbitrates line-granular requests from the page-table walker, the D-cache
// and the I-cache round-robin, and serialises them onto a single line-memory
// port one transaction at a time. The winner's address/we/wdata are captured
// at grant, a one-cycle memory command is issued, the arbiter waits for the
// memory completion, then pulses the winner's done for one cycle. Read data
// is returned on a shared rdata line that holds until the next read.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   ptw_req_i/ptw_addr_i          PTW line read request + word address
//   ptw_done_o                    one-cycle PTW completion
//   dc_req_i/dc_we_i/dc_addr_i    D-cache request, write enable, address
//   dc_wdata_i                    D-cache writeback line
//   dc_done_o                     one-cycle D-cache completion
//   ic_req_i/ic_addr_i            I-cache line read request + word address
//   ic_done_o                     one-cycle I-cache completion
//   rdata_o                       shared response line, valid with any done
//   mem_req_o                     one-cycle memory command strobe
//   mem_we_o/mem_addr_o           write enable, line-aligned word address
//   mem_wdata_o                   write line
//   mem_done_i/mem_rdata_i        memory completion + read line
//   busy_o                        high in every state except IDLE
//   gnt_id_o                      current/last grant (0 PTW, 1 DC, 2 IC)
// -----------------------------------------------------------------------------
module mem_line_arbiter
  import mem_line_arbiter_pkg::*;
#(
  parameter int XLEN           = XLEN_DEF,
  parameter int ADDR_BITS      = ADDR_BITS_DEF,
  parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF
) (
  input  logic                           clk_i,
  input  logic                           rst_i,

  input  logic                           ic_req_i,
  input  logic [ADDR_BITS-1:0]           ic_addr_i,
  output logic                           ic_done_o,

  input  logic                           dc_req_i,
  input  logic                           dc_we_i,
  input  logic [ADDR_BITS-1:0]           dc_addr_i,
  input  logic [XLEN*WORDS_PER_LINE-1:0] dc_wdata_i,
  output logic                           dc_done_o,

  input  logic                           ptw_req_i,
  input  logic [ADDR_BITS-1:0]           ptw_addr_i,
  output logic                           ptw_done_o,

  output logic [XLEN*WORDS_PER_LINE-1:0] rdata_o,

  output logic                           mem_req_o,
  output logic                           mem_we_o,
  output logic [ADDR_BITS-1:0]           mem_addr_o,
  output logic [XLEN*WORDS_PER_LINE-1:0] mem_wdata_o,
  input  logic                           mem_done_i,
  input  logic [XLEN*WORDS_PER_LINE-1:0] mem_rdata_i,

  output logic                           busy_o,
  output logic [1:0]                     gnt_id_o
);

  localparam int LINE_BITS   = line_bits(XLEN, WORDS_PER_LINE);
  localparam int OFFSET_BITS = $clog2(WORDS_PER_LINE);

  // Clears the word-within-line offset so memory always sees line-aligned
  // addresses.
  localparam logic [ADDR_BITS-1:0] LINE_MASK =
    ~ADDR_BITS'((1 << OFFSET_BITS) - 1);

  state_e               state_q;
  logic [1:0]           lastGnt_q;
  logic [1:0]           gntId_q;
  logic                 memReq_q;
  logic                 we_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [LINE_BITS-1:0] wdata_q;
  logic [LINE_BITS-1:0] rdata_q;
  logic                 busy_q;
  logic                 ptwDone_q;
  logic                 dcDone_q;
  logic                 icDone_q;

  logic [1:0]           winId_d;
  logic                 we_d;
  logic [ADDR_BITS-1:0] addr_d;
  logic [LINE_BITS-1:0] wdata_d;

  logic [2:0]           reqVec;
  logic [2:0]           gntOneHot;
  logic                 arbValid;

  assign reqVec[REQ_PTW] = ptw_req_i;
  assign reqVec[REQ_DC]  = dc_req_i;
  assign reqVec[REQ_IC]  = ic_req_i;

  rr_arbiter3 u_rr_arbiter3 (
    .req_i      (reqVec),
    .last_gnt_i (lastGnt_q),
    .gnt_o      (gntOneHot),
    .valid_o    (arbValid)
  );

  // Payload of the current winner. Only the D-cache can write, so the
  // read-only requesters present we = 0 and an all-zero write line.
  always_comb begin
    winId_d = REQ_PTW;
    we_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    if (gntOneHot[REQ_PTW]) begin
      winId_d = REQ_PTW;
      addr_d  = ptw_addr_i & LINE_MASK;
    end else if (gntOneHot[REQ_DC]) begin
      winId_d = REQ_DC;
      we_d    = dc_we_i;
      addr_d  = dc_addr_i & LINE_MASK;
      wdata_d = dc_wdata_i;
    end else if (gntOneHot[REQ_IC]) begin
      winId_d = REQ_IC;
      addr_d  = ic_addr_i & LINE_MASK;
    end
  end

  // Transaction FSM with all outputs registered. Requests are only looked
  // at in IDLE, so a requester that drops req on seeing its done is never
  // granted twice, and payload changes after grant have no effect. The
  // pointer resets to IC so the first search order is PTW > DC > IC.
  // mem_done is only honoured in WAIT.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      lastGnt_q <= REQ_IC;
      gntId_q   <= 2'd0;
      memReq_q  <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      ptwDone_q <= 1'b0;
      dcDone_q  <= 1'b0;
      icDone_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arbValid) begin
            gntId_q   <= winId_d;
            lastGnt_q <= winId_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            memReq_q  <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          memReq_q <= 1'b0;
          state_q  <= ST_WAIT;
        end

        ST_WAIT: begin
          if (mem_done_i) begin
            if (!we_q) begin
              rdata_q <= mem_rdata_i;
            end
            ptwDone_q <= (gntId_q == REQ_PTW);
            dcDone_q  <= (gntId_q == REQ_DC);
            icDone_q  <= (gntId_q == REQ_IC);
            state_q   <= ST_RESP;
          end
        end

        ST_RESP: begin
          ptwDone_q <= 1'b0;
          dcDone_q  <= 1'b0;
          icDone_q  <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end

        default: begin
          memReq_q  <= 1'b0;
          busy_q    <= 1'b0;
          ptwDone_q <= 1'b0;
          dcDone_q  <= 1'b0;
          icDone_q  <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign ptw_done_o  = ptwDone_q;
  assign dc_done_o   = dcDone_q;
  assign ic_done_o   = icDone_q;
  assign rdata_o     = rdata_q;
  assign mem_req_o   = memReq_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = busy_q;
  assign gnt_id_o    = gntId_q;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_line_arbiter
// Directed self-checking bench for mem_line_arbiter. The bench plays the
// memory and all three requesters from one initial block; every expected
// value is a hand-chosen constant.
// -----------------------------------------------------------------------------
module tb_mem_line_arbiter;

  localparam logic [1:0] ID_PTW = 2'd0;
  localparam logic [1:0] ID_DC  = 2'd1;
  localparam logic [1:0] ID_IC  = 2'd2;

  logic         clk_i;
  logic         rst_i;
  logic         ic_req_i;
  logic [19:0]  ic_addr_i;
  logic         ic_done_o;
  logic         dc_req_i;
  logic         dc_we_i;
  logic [19:0]  dc_addr_i;
  logic [127:0] dc_wdata_i;
  logic         dc_done_o;
  logic         ptw_req_i;
  logic [19:0]  ptw_addr_i;
  logic         ptw_done_o;
  logic [127:0] rdata_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [19:0]  mem_addr_o;
  logic [127:0] mem_wdata_o;
  logic         mem_done_i;
  logic [127:0] mem_rdata_i;
  logic         busy_o;
  logic [1:0]   gnt_id_o;

  int nCompared;
  int nMismatch;

  mem_line_arbiter dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .ic_req_i    (ic_req_i),
    .ic_addr_i   (ic_addr_i),
    .ic_done_o   (ic_done_o),
    .dc_req_i    (dc_req_i),
    .dc_we_i     (dc_we_i),
    .dc_addr_i   (dc_addr_i),
    .dc_wdata_i  (dc_wdata_i),
    .dc_done_o   (dc_done_o),
    .ptw_req_i   (ptw_req_i),
    .ptw_addr_i  (ptw_addr_i),
    .ptw_done_o  (ptw_done_o),
    .rdata_o     (rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_done_i  (mem_done_i),
    .mem_rdata_i (mem_rdata_i),
    .busy_o      (busy_o),
    .gnt_id_o    (gnt_id_o)
  );

  // Free-running 10-time-unit clock.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Hard stop in case a wait goes wrong somewhere unforeseen.
  initial begin
    #200000;
    $display("[TB] FAIL global-timeout: observed no finish, required finish before 200000");
    $fatal(1, "[TB] timeout");
  end

  // Advance one clock and settle just past the rising edge, where outputs
  // are sampled and inputs are changed.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatch++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Hold reset for two cycles with all requests low, then release it.
  task automatic applyStimulus();
    rst_i       = 1'b1;
    ic_req_i    = 1'b0;
    dc_req_i    = 1'b0;
    ptw_req_i   = 1'b0;
    mem_done_i  = 1'b0;
    mem_rdata_i = '0;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  // One complete transaction as seen from the memory side: wait (bounded)
  // for the command, check it, answer after extraWait further WAIT cycles,
  // check the response, drop the winner's req and step back into IDLE.
  task automatic doTxn(input string tag, input logic [1:0] expId,
                       input logic [19:0] expAddr, input logic expWe,
                       input logic [127:0] expWdata, input int extraWait,
                       input logic [127:0] memLine, input logic [127:0] expRdata);
    logic seen;
    logic [2:0] expDone;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req_o) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    checkOutput({tag, " mem_req seen"}, 128'(seen), 128'(1'b1));
    checkOutput({tag, " gnt_id"}, 128'(gnt_id_o), 128'(expId));
    checkOutput({tag, " mem_addr"}, 128'(mem_addr_o), 128'(expAddr));
    checkOutput({tag, " mem_we"}, 128'(mem_we_o), 128'(expWe));
    if (expWe) begin
      checkOutput({tag, " mem_wdata"}, mem_wdata_o, expWdata);
    end
    tick();
    checkOutput({tag, " mem_req one cycle"}, 128'(mem_req_o), 128'(1'b0));
    repeat (extraWait) tick();
    mem_done_i  = 1'b1;
    mem_rdata_i = memLine;
    tick();
    mem_done_i = 1'b0;
    expDone = 3'b001 << expId;
    checkOutput({tag, " done {ic,dc,ptw}"}, 128'({ic_done_o, dc_done_o, ptw_done_o}),
                128'(expDone));
    checkOutput({tag, " rdata"}, rdata_o, expRdata);
    case (expId)
      ID_PTW:  ptw_req_i = 1'b0;
      ID_DC:   dc_req_i  = 1'b0;
      default: ic_req_i  = 1'b0;
    endcase
    tick();
    checkOutput({tag, " done cleared"}, 128'({ic_done_o, dc_done_o, ptw_done_o}), 128'(0));
    checkOutput({tag, " busy idle"}, 128'(busy_o), 128'(1'b0));
  endtask

  localparam logic [127:0] LINE1  = {32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'h00000001};
  localparam logic [127:0] LINE_P = {4{32'h11110000}};
  localparam logic [127:0] LINE_D = {4{32'h22220000}};
  localparam logic [127:0] LINE_I = {4{32'h33330000}};
  localparam logic [127:0] WB     = {4{32'h000000AA}};
  localparam logic [127:0] JUNK   = {4{32'hBADBAD00}};
  localparam logic [127:0] LINE5  = {4{32'h55555555}};
  localparam logic [127:0] LINE6  = {4{32'h66666666}};

  initial begin
    logic [127:0] contLine;
    logic [127:0] lastRead;
    logic [1:0]   contId;
    nCompared  = 0;
    nMismatch  = 0;
    ic_addr_i  = '0;
    dc_addr_i  = '0;
    dc_we_i    = 1'b0;
    dc_wdata_i = '0;
    ptw_addr_i = '0;

    // ---- Reset values ----
    applyStimulus();
    checkOutput("reset busy", 128'(busy_o), 128'(1'b0));
    checkOutput("reset mem_req", 128'(mem_req_o), 128'(1'b0));
    checkOutput("reset mem_we", 128'(mem_we_o), 128'(1'b0));
    checkOutput("reset mem_addr", 128'(mem_addr_o), 128'(0));
    checkOutput("reset mem_wdata", mem_wdata_o, 128'(0));
    checkOutput("reset rdata", rdata_o, 128'(0));
    checkOutput("reset gnt_id", 128'(gnt_id_o), 128'(0));
    checkOutput("reset dones", 128'({ic_done_o, dc_done_o, ptw_done_o}), 128'(0));

    // ---- Single I-cache read, done at grant+6 ----
    ic_addr_i = 20'h00013;
    ic_req_i  = 1'b1;
    tick();                                   // grant edge -> ISSUE
    checkOutput("ic1 mem_req", 128'(mem_req_o), 128'(1'b1));
    checkOutput("ic1 mem_addr", 128'(mem_addr_o), 128'(20'h00010));
    checkOutput("ic1 mem_we", 128'(mem_we_o), 128'(1'b0));
    checkOutput("ic1 gnt_id", 128'(gnt_id_o), 128'(ID_IC));
    checkOutput("ic1 busy", 128'(busy_o), 128'(1'b1));
    ic_addr_i = 20'h00777;                    // payload change after grant
    tick();                                   // WAIT 1
    checkOutput("ic1 mem_req dropped", 128'(mem_req_o), 128'(1'b0));
    tick();                                   // WAIT 2
    tick();                                   // WAIT 3
    checkOutput("ic1 no early done", 128'(ic_done_o), 128'(1'b0));
    tick();                                   // WAIT 4
    checkOutput("ic1 still waiting", 128'(ic_done_o), 128'(1'b0));
    mem_done_i  = 1'b1;
    mem_rdata_i = LINE1;
    tick();                                   // RESP = grant+6
    mem_done_i = 1'b0;
    checkOutput("ic1 done", 128'({ic_done_o, dc_done_o, ptw_done_o}), 128'(3'b100));
    checkOutput("ic1 rdata", rdata_o, LINE1);
    checkOutput("ic1 mem_addr held", 128'(mem_addr_o), 128'(20'h00010));
    ic_req_i = 1'b0;
    tick();
    checkOutput("ic1 done one cycle", 128'(ic_done_o), 128'(1'b0));
    checkOutput("ic1 busy idle", 128'(busy_o), 128'(1'b0));
    checkOutput("ic1 rdata holds", rdata_o, LINE1);

    // ---- Simultaneous requests right after reset: PTW, D, I ----
    applyStimulus();
    ptw_addr_i = 20'h00101;
    dc_addr_i  = 20'h00206;
    dc_we_i    = 1'b0;
    ic_addr_i  = 20'h0030F;
    ptw_req_i  = 1'b1;
    dc_req_i   = 1'b1;
    ic_req_i   = 1'b1;
    doTxn("all3 ptw", ID_PTW, 20'h00100, 1'b0, '0, 0, LINE_P, LINE_P);
    doTxn("all3 dc",  ID_DC,  20'h00204, 1'b0, '0, 1, LINE_D, LINE_D);
    doTxn("all3 ic",  ID_IC,  20'h0030C, 1'b0, '0, 2, LINE_I, LINE_I);

    // ---- Continuous D/I contention: D, I, D, I, D, I ----
    dc_addr_i = 20'h00040;
    ic_addr_i = 20'h00081;
    dc_req_i  = 1'b1;
    ic_req_i  = 1'b1;
    lastRead  = '0;
    for (int k = 0; k < 6; k++) begin
      contId   = (k % 2 == 0) ? ID_DC : ID_IC;
      contLine = {32'hC0DE0000 + 32'(k), 96'h0};
      doTxn($sformatf("cont%0d", k), contId,
            (contId == ID_DC) ? 20'h00040 : 20'h00080, 1'b0, '0, k % 2,
            contLine, contLine);
      lastRead = contLine;
      if (k < 5) begin
        if (contId == ID_DC) dc_req_i = 1'b1;
        else                 ic_req_i = 1'b1;
      end
    end
    dc_req_i = 1'b0;

    // ---- D-cache writeback leaves rdata unchanged ----
    dc_we_i    = 1'b1;
    dc_addr_i  = 20'h00024;
    dc_wdata_i = WB;
    dc_req_i   = 1'b1;
    doTxn("wb", ID_DC, 20'h00024, 1'b1, WB, 1, JUNK, lastRead);
    dc_we_i = 1'b0;

    // ---- Reset in WAIT aborts; stale mem_done ignored; PTW first ----
    ptw_addr_i = 20'h000AB;
    ptw_req_i  = 1'b1;
    tick();                                   // ISSUE
    checkOutput("abort mem_addr", 128'(mem_addr_o), 128'(20'h000A8));
    tick();                                   // WAIT
    rst_i = 1'b1;
    tick();
    rst_i     = 1'b0;
    ptw_req_i = 1'b0;
    checkOutput("abort busy", 128'(busy_o), 128'(1'b0));
    checkOutput("abort dones", 128'({ic_done_o, dc_done_o, ptw_done_o}), 128'(0));
    checkOutput("abort mem_req", 128'(mem_req_o), 128'(1'b0));
    tick();
    mem_done_i  = 1'b1;
    mem_rdata_i = JUNK;
    tick();
    mem_done_i = 1'b0;
    checkOutput("stale busy", 128'(busy_o), 128'(1'b0));
    checkOutput("stale dones", 128'({ic_done_o, dc_done_o, ptw_done_o}), 128'(0));
    checkOutput("stale rdata", rdata_o, 128'(0));
    ptw_addr_i = 20'h000C0;
    dc_addr_i  = 20'h000D1;
    ic_addr_i  = 20'h000E2;
    ptw_req_i  = 1'b1;
    dc_req_i   = 1'b1;
    ic_req_i   = 1'b1;
    doTxn("postrst ptw", ID_PTW, 20'h000C0, 1'b0, '0, 0, LINE5, LINE5);
    dc_req_i = 1'b0;
    ic_req_i = 1'b0;
    tick();
    checkOutput("postrst idle", 128'(busy_o), 128'(1'b0));

    // ---- Spurious mem_done in IDLE and in ISSUE ----
    mem_done_i  = 1'b1;
    mem_rdata_i = JUNK;
    tick();
    mem_done_i = 1'b0;
    checkOutput("spur idle busy", 128'(busy_o), 128'(1'b0));
    checkOutput("spur idle mem_req", 128'(mem_req_o), 128'(1'b0));
    checkOutput("spur idle dones", 128'({ic_done_o, dc_done_o, ptw_done_o}), 128'(0));
    checkOutput("spur idle rdata", rdata_o, LINE5);
    ic_addr_i = 20'h00055;
    ic_req_i  = 1'b1;
    tick();                                   // ISSUE
    checkOutput("spur issue mem_req", 128'(mem_req_o), 128'(1'b1));
    mem_done_i  = 1'b1;
    mem_rdata_i = JUNK;
    tick();                                   // WAIT, done in ISSUE ignored
    mem_done_i = 1'b0;
    checkOutput("spur issue no done", 128'(ic_done_o), 128'(1'b0));
    checkOutput("spur issue busy", 128'(busy_o), 128'(1'b1));
    tick();
    checkOutput("spur wait no done", 128'(ic_done_o), 128'(1'b0));
    checkOutput("spur wait rdata", rdata_o, LINE5);
    mem_done_i  = 1'b1;
    mem_rdata_i = LINE6;
    tick();                                   // RESP
    mem_done_i = 1'b0;
    checkOutput("spur done", 128'({ic_done_o, dc_done_o, ptw_done_o}), 128'(3'b100));
    checkOutput("spur rdata", rdata_o, LINE6);
    checkOutput("spur mem_addr", 128'(mem_addr_o), 128'(20'h00054));
    ic_req_i = 1'b0;
    tick();
    checkOutput("spur end busy", 128'(busy_o), 128'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
